fdown_game_ctrl: RTL and testbench

- Per-frame game-state controller for the fall-down VGA game.
- Owns the ball position, the three floor rows and their gaps, and the score; the ball and floor renderers read these directly.
- Sequences one physics update per frame tick: floor scroll and respawn, horizontal move, fall/collision resolve, game-over check.
- Replaces the free-running xPos/yPos/floor registers in the top level.

---
 rtl/fdown_pkg.sv | 65 ++++++
 rtl/fdown_lfsr16.sv | 27 ++
 rtl/fdown_game_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fdown_game_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fdown_pkg.sv
// Shared constants, state encoding and helpers for the fall-down game controller.
// Gap generation and LFSR stepping live here so every user agrees on them.
package fdown_pkg;

    localparam logic [9:0]  SCR_W       = 10'd640;
    localparam logic [9:0]  SCR_H       = 10'd480;
    localparam logic [9:0]  RST_X       = 10'd120;
    localparam logic [9:0]  RST_Y       = 10'd240;
    localparam logic [29:0] RST_FLOORS  = {10'd100, 10'd250, 10'd400};
    localparam logic [29:0] RST_GAPS    = {10'd200, 10'd300, 10'd150};
    localparam logic [29:0] RST_WIDTHS  = {10'd40, 10'd35, 10'd60};
    localparam logic [9:0]  GAP_POS_MAX = SCR_W - 10'd64;
    localparam logic [9:0]  GAP_WRAP    = 10'd256;
    localparam logic [9:0]  GAP_MIN_W   = 10'd32;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WAIT   = 4'd1,
        ST_SCROLL = 4'd2,
        ST_MOVE   = 4'd3,
        ST_CHK0   = 4'd4,
        ST_CHK1   = 4'd5,
        ST_CHK2   = 4'd6,
        ST_COMMIT = 4'd7,
        ST_OVER   = 4'd8
    } state_e;

    function automatic logic [29:0] pack3(input logic [9:0] f0, input logic [9:0] f1,
                                          input logic [9:0] f2);
        return {f0, f1, f2};
    endfunction

    function automatic logic [9:0] unpack3(input logic [29:0] v, input logic [1:0] idx);
        logic [9:0] r;
        case (idx)
            2'd0:    r = v[29:20];
            2'd1:    r = v[19:10];
            default: r = v[9:0];
        endcase
        return r;
    endfunction

    // Fibonacci taps 16,14,13,11 in right-shift form: feedback enters at bit 15.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [9:0] gap_width(input logic [3:0] sel);
        return GAP_MIN_W + {5'd0, sel, 1'b0};
    endfunction

    function automatic logic [9:0] gap_pos(input logic [8:0] raw);
        logic [9:0] p;
        p = {1'b0, raw};
        if (p > GAP_POS_MAX) begin
            p = p - GAP_WRAP;
        end else begin
            p = p;
        end
        return p;
    endfunction

endpackage

// File: rtl/fdown_lfsr16.sv
// Free-running 16-bit gap generator; reloads its seed on reset.
module fdown_lfsr16
    import fdown_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // One LFSR step per enabled clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end else begin
            r_state <= r_state;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/fdown_game_ctrl.sv
// Per-frame game-state controller: scrolls floors, moves and drops the ball,
// resolves floor landings one floor per clock, and detects game over.
module fdown_game_ctrl
    import fdown_pkg::*;
#(
    parameter logic [9:0]  SCROLL     = 10'd1,
    parameter logic [9:0]  X_STEP     = 10'd2,
    parameter logic [9:0]  FALL_STEP  = 10'd3,
    parameter logic [9:0]  BALL_SIZE  = 10'd8,
    parameter logic [9:0]  TOP_MARGIN = 10'd4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [1:0]  dir,
    input  logic        start,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [29:0] floors_y_pos,
    output logic [29:0] gaps_pos,
    output logic [29:0] gaps_width,
    output logic [15:0] score,
    output logic        game_over,
    output logic        update_done
);

    localparam logic [9:0]  X_MAX = SCR_W - BALL_SIZE;
    localparam logic [9:0]  Y_MAX = SCR_H - BALL_SIZE;
    localparam logic [10:0] B11   = {1'b0, BALL_SIZE};

    state_e      r_state;
    logic [9:0]  r_x, r_y;
    logic [9:0]  r_fy [3];
    logic [9:0]  r_gp [3];
    logic [9:0]  r_gw [3];
    logic [15:0] r_score;
    logic        r_on, r_on_next, r_over, r_done;
    logic [10:0] r_ycand;

    logic [15:0] w_lfsr, w_lf, w_sc;
    logic [9:0]  w_fy_n [3];
    logic [9:0]  w_gp_n [3];
    logic [9:0]  w_gw_n [3];
    logic [9:0]  w_x_n;
    logic [10:0] w_x_sum;
    logic [9:0]  w_chk_fy, w_chk_gp, w_chk_gw;
    state_e      w_chk_next;
    logic        w_in_gap, w_hit, w_restart, w_on_commit;
    logic [10:0] w_ybot, w_land;
    logic [9:0]  w_y_commit;

    fdown_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (1'b1),
        .i_seed  (LFSR_SEED),
        .o_state (w_lfsr)
    );

    // Scroll every floor; respawning floors consume successive LFSR states.
    always_comb begin
        w_lf = w_lfsr;
        w_sc = r_score;
        for (int i = 0; i < 3; i++) begin
            if (r_fy[i] < SCROLL) begin
                w_fy_n[i] = SCR_H - 10'd1;
                w_gp_n[i] = gap_pos(w_lf[8:0]);
                w_gw_n[i] = gap_width(w_lf[12:9]);
                if (w_sc != 16'hFFFF) begin
                    w_sc = w_sc + 16'd1;
                end else begin
                    w_sc = w_sc;
                end
                w_lf = lfsr_next(w_lf);
            end else begin
                w_fy_n[i] = r_fy[i] - SCROLL;
                w_gp_n[i] = r_gp[i];
                w_gw_n[i] = r_gw[i];
            end
        end
    end

    // Horizontal move with clamping at both screen edges.
    always_comb begin
        w_x_sum = {1'b0, r_x} + {1'b0, X_STEP};
        case (dir)
            2'b10:   w_x_n = (r_x >= X_STEP) ? (r_x - X_STEP) : 10'd0;
            2'b01:   w_x_n = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[9:0];
            default: w_x_n = r_x;
        endcase
    end

    // Floor under test for the current CHK state, and the landing test on it.
    always_comb begin
        case (r_state)
            ST_CHK1: begin
                w_chk_fy = r_fy[1]; w_chk_gp = r_gp[1]; w_chk_gw = r_gw[1];
                w_chk_next = ST_CHK2;
            end
            ST_CHK2: begin
                w_chk_fy = r_fy[2]; w_chk_gp = r_gp[2]; w_chk_gw = r_gw[2];
                w_chk_next = ST_COMMIT;
            end
            default: begin
                w_chk_fy = r_fy[0]; w_chk_gp = r_gp[0]; w_chk_gw = r_gw[0];
                w_chk_next = ST_CHK1;
            end
        endcase
        w_ybot   = {1'b0, r_y} + B11;
        w_in_gap = (r_x >= w_chk_gp) &&
                   (({1'b0, r_x} + B11) <= ({1'b0, w_chk_gp} + {1'b0, w_chk_gw}));
        w_hit    = !w_in_gap && (w_ybot <= {1'b0, w_chk_fy}) &&
                   ((w_ybot + {1'b0, FALL_STEP}) >= {1'b0, w_chk_fy});
        w_land   = {1'b0, w_chk_fy} - B11;
    end

    // Bottom-edge clamp: a ball resting there is not riding any floor.
    always_comb begin
        if (r_ycand > {1'b0, Y_MAX}) begin
            w_y_commit  = Y_MAX;
            w_on_commit = 1'b0;
        end else begin
            w_y_commit  = r_ycand[9:0];
            w_on_commit = r_on_next;
        end
    end

    assign w_restart = (r_state == ST_OVER) && start;

    // Game FSM; a restart from OVER reloads the same values as reset but lands in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n || w_restart) begin
            r_state   <= rst_n ? ST_WAIT : ST_IDLE;
            r_x       <= RST_X;
            r_y       <= RST_Y;
            for (int i = 0; i < 3; i++) begin
                r_fy[i] <= unpack3(RST_FLOORS, 2'(i));
                r_gp[i] <= unpack3(RST_GAPS, 2'(i));
                r_gw[i] <= unpack3(RST_WIDTHS, 2'(i));
            end
            r_score   <= 16'd0;
            r_on      <= 1'b0;
            r_on_next <= 1'b0;
            r_ycand   <= 11'd0;
            r_over    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (frame_tick) r_state <= ST_SCROLL;
                end
                ST_SCROLL: begin
                    for (int i = 0; i < 3; i++) begin
                        r_fy[i] <= w_fy_n[i];
                        r_gp[i] <= w_gp_n[i];
                        r_gw[i] <= w_gw_n[i];
                    end
                    r_score <= w_sc;
                    if (r_on) r_y <= r_y - SCROLL;
                    r_state <= ST_MOVE;
                end
                ST_MOVE: begin
                    r_x       <= w_x_n;
                    r_ycand   <= {1'b0, r_y} + {1'b0, FALL_STEP};
                    r_on_next <= 1'b0;
                    r_state   <= ST_CHK0;
                end
                ST_CHK0, ST_CHK1, ST_CHK2: begin
                    if (w_hit) begin
                        if (w_land < r_ycand) r_ycand <= w_land;
                        r_on_next <= 1'b1;
                    end
                    r_done  <= (r_state == ST_CHK2);
                    r_state <= w_chk_next;
                end
                ST_COMMIT: begin
                    r_y  <= w_y_commit;
                    r_on <= w_on_commit;
                    if (w_y_commit < TOP_MARGIN) begin
                        r_state <= ST_OVER;
                        r_over  <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_pos        = r_x;
    assign y_pos        = r_y;
    assign floors_y_pos = pack3(r_fy[0], r_fy[1], r_fy[2]);
    assign gaps_pos     = pack3(r_gp[0], r_gp[1], r_gp[2]);
    assign gaps_width   = pack3(r_gw[0], r_gw[1], r_gw[2]);
    assign score        = r_score;
    assign game_over    = r_over;
    assign update_done  = r_done;

endmodule

// File: tb/tb_fdown_game_ctrl.sv
// Self-checking bench: a scripted game table, directed corner sequences and
// random play against a frame-level reference model of the game rules.
module tb_fdown_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  dir = 2'b00;
    logic        start = 1'b0;
    logic [9:0]  x_pos, y_pos;
    logic [29:0] floors_y_pos, gaps_pos, gaps_width;
    logic [15:0] score;
    logic        game_over, update_done;

    fdown_game_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .dir          (dir),
        .start        (start),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .floors_y_pos (floors_y_pos),
        .gaps_pos     (gaps_pos),
        .gaps_width   (gaps_width),
        .score        (score),
        .game_over    (game_over),
        .update_done  (update_done)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

    int n_chk = 0, n_err = 0;
    int m_lfsr;
    int mx, my, mon, mscore, m_mode;
    int mfy [3], mgp [3], mgw [3];

    typedef struct {
        int         ticks;
        logic [1:0] d;
        int         ex, ey, ef0, ef1, ef2, escore, eover;
    } vec_t;
    vec_t tbl [11];

    function automatic int lstep(input int s);
        int fb;
        fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return (s >> 1) | (fb << 15);
    endfunction

    // Gap generator state as it evolves clock by clock from the seed.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 32'hACE1;
        else        m_lfsr <= lstep(m_lfsr);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_load();
        mx = 120; my = 240; mon = 0; mscore = 0;
        mfy = '{100, 250, 400};
        mgp = '{200, 300, 150};
        mgw = '{40, 35, 60};
    endtask

    task automatic model_frame(input logic [1:0] d, input int l0);
        int lf, cand, onn;
        bit ing;
        lf = l0;
        for (int i = 0; i < 3; i++) begin
            if (mfy[i] < 1) begin
                mfy[i] = 479;
                mgw[i] = 32 + 2 * ((lf >> 9) & 15);
                mgp[i] = lf & 511;
                if (mgp[i] > 576) mgp[i] -= 256;
                if (mscore < 65535) mscore++;
                lf = lstep(lf);
            end else begin
                mfy[i] -= 1;
            end
        end
        if (mon != 0) my -= 1;
        if (d == 2'b10) mx = (mx >= 2) ? mx - 2 : 0;
        else if (d == 2'b01) mx = (mx + 2 > 632) ? 632 : mx + 2;
        cand = my + 3;
        onn = 0;
        for (int i = 0; i < 3; i++) begin
            ing = (mx >= mgp[i]) && (mx + 8 <= mgp[i] + mgw[i]);
            if (!ing && my + 8 <= mfy[i] && my + 11 >= mfy[i]) begin
                if (mfy[i] - 8 < cand) cand = mfy[i] - 8;
                onn = 1;
            end
        end
        if (cand > 472) begin my = 472; mon = 0; end
        else begin my = cand; mon = onn; end
        if (my < 4) m_mode = M_OVER;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pos"}, {x_pos, y_pos}, {10'(mx), 10'(my)});
        chk({tag, "_floors"}, floors_y_pos, {10'(mfy[0]), 10'(mfy[1]), 10'(mfy[2])});
        chk({tag, "_gaps"}, gaps_pos, {10'(mgp[0]), 10'(mgp[1]), 10'(mgp[2])});
        chk({tag, "_widths"}, gaps_width, {10'(mgw[0]), 10'(mgw[1]), 10'(mgw[2])});
        chk({tag, "_score_over"}, {score, game_over}, {16'(mscore), (m_mode == M_OVER)});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pos"}, {x_pos, y_pos}, {10'd120, 10'd240});
        chk({tag, "_floors"}, floors_y_pos, {10'd100, 10'd250, 10'd400});
        chk({tag, "_gaps"}, {gaps_pos, gaps_width},
            {10'd200, 10'd300, 10'd150, 10'd40, 10'd35, 10'd60});
        chk({tag, "_flags"}, {score, game_over, update_done}, 18'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (m_mode == M_OVER) begin
            model_load();
            m_mode = M_RUN;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
        end
    endtask

    // One frame: tick, optional stray tick mid-update, then 8 clocks of observation.
    task automatic do_tick(input logic [1:0] d, input bit extra);
        int lat, np, snap;
        bit active;
        dir = d;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        snap = m_lfsr;
        frame_tick = 1'b0;
        lat = -1;
        np = 0;
        for (int i = 2; i <= 8; i++) begin
            frame_tick = (extra && i == 3);
            @(posedge clk); #1;
            if (update_done) begin
                np++;
                lat = i;
            end
        end
        frame_tick = 1'b0;
        active = (m_mode == M_RUN);
        if (active) model_frame(d, snap);
        chk("done_latency", {4'(np), 8'(lat)}, active ? {4'd1, 8'd6} : {4'd0, 8'hFF});
    endtask

    initial begin
        logic [9:0] w;
        logic [1:0] cur;

        tbl[0]  = '{1,   2'b00, 120, 241, 99,  249, 399, 0, 0};
        tbl[1]  = '{1,   2'b00, 120, 240, 98,  248, 398, 0, 0};
        tbl[2]  = '{10,  2'b01, 140, 230, 88,  238, 388, 0, 0};
        tbl[3]  = '{10,  2'b10, 120, 220, 78,  228, 378, 0, 0};
        tbl[4]  = '{63,  2'b10, 0,   157, 15,  165, 315, 0, 0};
        tbl[5]  = '{3,   2'b10, 0,   154, 12,  162, 312, 0, 0};
        tbl[6]  = '{12,  2'b00, 0,   142, 0,   150, 300, 0, 0};
        tbl[7]  = '{1,   2'b00, 0,   141, 479, 149, 299, 1, 0};
        tbl[8]  = '{137, 2'b00, 0,   4,   342, 12,  162, 1, 0};
        tbl[9]  = '{1,   2'b00, 0,   3,   341, 11,  161, 1, 1};
        tbl[10] = '{2,   2'b01, 0,   3,   341, 11,  161, 1, 1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        model_load();
        m_mode = M_IDLE;

        do_tick(2'b10, 1'b0);
        chk_model("idle_hold");
        do_start();

        for (int r = 0; r < 11; r++) begin
            for (int t = 0; t < tbl[r].ticks; t++) do_tick(tbl[r].d, 1'b0);
            chk($sformatf("row%0d_pos", r), {x_pos, y_pos}, {10'(tbl[r].ex), 10'(tbl[r].ey)});
            chk($sformatf("row%0d_floors", r), floors_y_pos,
                {10'(tbl[r].ef0), 10'(tbl[r].ef1), 10'(tbl[r].ef2)});
            chk($sformatf("row%0d_score_over", r), {score, game_over},
                {16'(tbl[r].escore), 1'(tbl[r].eover)});
            if (r == 7) begin
                w = gaps_width[29:20];
                chk("respawn_width_range", {(w >= 10'd32), (w <= 10'd62), w[0]}, 3'b110);
                chk("respawn_pos_range", (gaps_pos[29:20] <= 10'd576), 1'b1);
                chk_model("respawn");
            end
        end

        do_start();
        chk_reset_vals("restart");
        chk_model("restart_model");

        // Reset asserted while an update is in flight.
        dir = 2'b01;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("mid_reset");
        rst_n = 1'b1;
        model_load();
        m_mode = M_IDLE;
        do_start();

        for (int k = 0; k < 300; k++) begin
            if (m_mode == M_OVER) do_start();
            do_tick(2'b01, (k % 5) == 0);
            chk_model($sformatf("right%0d", k));
        end
        chk("x_right_clamp", x_pos, 10'd632);

        cur = 2'b00;
        for (int k = 0; k < 300; k++) begin
            if (m_mode == M_OVER) do_start();
            if ($urandom_range(0, 3) == 0) cur = 2'($urandom_range(0, 3));
            do_tick(cur, $urandom_range(0, 7) == 0);
            chk_model($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
